// File: rtl/checkbits_monitor.sv
// Watches a checkbits bus for an ordered list of markers with a per-marker timeout.
// Optional CHECKBITS_MON_STRICT_ORDER_EN: fail on any later marker seen before the expected one.
module checkbits_monitor #(
  parameter int WIDTH    = 16,
  parameter int NUM_MARK = 4,
  parameter int TO_W     = 24
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              checkbits,
  input  logic [NUM_MARK*WIDTH-1:0]     marker_list,
  input  logic [TO_W-1:0]               timeout_cycles,
  output logic                          busy,
  output logic                          pass,
  output logic                          fail,
  output logic [1:0]                    fail_code,
  output logic [$clog2(NUM_MARK+1)-1:0] match_idx,
  output logic                          change_pulse,
  output logic [15:0]                   change_cnt
);
  localparam int IDX_W = $clog2(NUM_MARK+1);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [1:0]       code_q, code_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] cur_mark;
  logic             hit;
  logic             ooo;

  // Mux by compare so an index of NUM_MARK (only reachable in PASS) never slices out of range.
  always_comb begin
    cur_mark = '0;
    for (int i = 0; i < NUM_MARK; i++)
      if (idx_q == IDX_W'(i)) cur_mark = marker_list[i*WIDTH +: WIDTH];
  end

  assign hit = (state_q == RUN) && (checkbits == cur_mark);

`ifdef CHECKBITS_MON_STRICT_ORDER_EN
  always_comb begin
    ooo = 1'b0;
    for (int j = 0; j < NUM_MARK; j++)
      if ((IDX_W'(j) > idx_q) && (checkbits == marker_list[j*WIDTH +: WIDTH])) ooo = 1'b1;
  end
`else
  assign ooo = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    change_pulse = (state_q == RUN) && (checkbits != prev_q);
    if (start) begin
      state_d = RUN;
      idx_d   = '0;
      timer_d = '0;
      code_d  = 2'd0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      if (change_pulse && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
      // Match beats both failure causes; order violation beats timeout.
      if (hit) begin
        idx_d   = idx_q + IDX_W'(1);
        timer_d = '0;
        if (idx_q == IDX_W'(NUM_MARK-1)) state_d = PASS;
      end else if (ooo) begin
        state_d = FAIL;
        code_d  = 2'd2;
      end else if (timeout_cycles != '0) begin
        if (timer_q == timeout_cycles - TO_W'(1)) begin
          state_d = FAIL;
          code_d  = 2'd1;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      code_q  <= 2'd0;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      prev_q  <= checkbits;
    end
  end

  assign busy       = (state_q == RUN);
  assign pass       = (state_q == PASS);
  assign fail       = (state_q == FAIL);
  assign fail_code  = code_q;
  assign match_idx  = idx_q;
  assign change_cnt = cnt_q;
endmodule

// File: tb/tb_checkbits_monitor.sv
// Directed bench for checkbits_monitor (WIDTH=16, NUM_MARK=2).
module tb_checkbits_monitor;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] checkbits;
  logic [31:0] marker_list;
  logic [23:0] timeout_cycles;
  logic        busy, pass, fail, change_pulse;
  logic [1:0]  fail_code;
  logic [1:0]  match_idx;
  logic [15:0] change_cnt;

  int n_run  = 0;
  int n_fail = 0;

  checkbits_monitor #(.WIDTH(16), .NUM_MARK(2), .TO_W(24)) dut (
    .clock(clock), .reset(reset), .start(start), .checkbits(checkbits),
    .marker_list(marker_list), .timeout_cycles(timeout_cycles),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .match_idx(match_idx), .change_pulse(change_pulse), .change_cnt(change_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; checkbits = '0;
    marker_list = {16'hAB51, 16'hAB40}; timeout_cycles = 24'd1000;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_idx", match_idx, 0);
    chk("rst_cnt", change_cnt, 0);
    chk("rst_pulse", change_pulse, 0);

    // basic pass with an unrelated value between markers
    arm();
    chk("arm_busy", busy, 1);
    checkbits = 16'hAB40; #1;
    chk("chg_pulse", change_pulse, 1);
    tick();
    chk("m1_idx", match_idx, 1);
    checkbits = 16'h0028; tick();
    checkbits = 16'hAB51; #1;
    chk("pre_pass", pass, 0);
    tick();
    chk("pass", pass, 1);
    chk("pass_idx", match_idx, 2);
    chk("pass_cnt", change_cnt, 3);
    chk("pass_busy", busy, 0);
    chk("pass_pulse", change_pulse, 0);
    tick();
    chk("pass_hold", pass, 1);

    // timeout of 1000 after first match
    arm();
    checkbits = 16'hAB40; tick();
    checkbits = 16'h0000;
    repeat (999) tick();
    chk("to_999_fail", fail, 0);
    chk("to_999_busy", busy, 1);
    tick();
    chk("to_1000_fail", fail, 1);
    chk("to_1000_code", fail_code, 1);

    // timeout 5: match on timer=4 wins
    timeout_cycles = 24'd5;
    arm();
    checkbits = 16'hAB40; tick();
    checkbits = 16'h0000; repeat (4) tick();
    checkbits = 16'hAB51; tick();
    chk("to5_pass", pass, 1);
    chk("to5_nofail", fail, 0);
    // same but no match on timer=4
    arm();
    checkbits = 16'hAB40; tick();
    checkbits = 16'h0000; repeat (4) tick();
    chk("to5_busy", busy, 1);
    tick();
    chk("to5_fail", fail, 1);
    chk("to5_code", fail_code, 1);

    // out-of-order marker
    timeout_cycles = 24'd1000;
    arm();
    checkbits = 16'hAB51; tick();
`ifdef CHECKBITS_MON_STRICT_ORDER_EN
    chk("ooo_fail", fail, 1);
    chk("ooo_code", fail_code, 2);
`else
    chk("ooo_busy", busy, 1);
    chk("ooo_idx", match_idx, 0);
    checkbits = 16'hAB40; tick();
    checkbits = 16'hAB51; tick();
    chk("ooo_pass", pass, 1);
    chk("ooo_code", fail_code, 0);
`endif

    // reset mid-run
    arm();
    checkbits = 16'hAB40; tick();
    chk("mid_idx", match_idx, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_pass", pass, 0);
    chk("mid_fail", fail, 0);
    chk("mid_code", fail_code, 0);
    chk("mid_idx0", match_idx, 0);
    chk("mid_cnt", change_cnt, 0);
    chk("mid_pulse", change_pulse, 0);
    arm();
    checkbits = 16'hAB40; tick();
    checkbits = 16'hAB51; tick();
    chk("rearm_pass", pass, 1);

    // identical consecutive markers advance on consecutive cycles
    marker_list = {16'h1234, 16'h1234};
    checkbits = 16'h0000;
    arm();
    checkbits = 16'h1234; tick();
    chk("dup_idx1", match_idx, 1);
    chk("dup_nopass", pass, 0);
    tick();
    chk("dup_idx2", match_idx, 2);
    chk("dup_pass", pass, 1);

    // timeout disabled and change_cnt saturation
    marker_list = {16'hAB51, 16'hAB40};
    timeout_cycles = 24'd0;
    arm();
    for (int k = 0; k < 65540; k++) begin
      checkbits = (k % 2 == 0) ? 16'h0001 : 16'h0002;
      tick();
    end
    chk("sat_cnt", change_cnt, 16'hFFFF);
    chk("sat_busy", busy, 1);
    arm();
    chk("rearm_cnt", change_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/checkbits_monitor.md
CHECKBITS_MONITOR -- requirements
Module: checkbits_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of the monitored checkbits bus.
REQ-002 SHALL have parameter NUM_MARK, default 4, number of ordered markers (>=1).
REQ-003 SHALL have parameter TO_W, default 24, width of the timeout counter and threshold.
REQ-004 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  single-cycle pulse that arms or re-arms the monitor.
REQ-007 SHALL have port: checkbits  input  WIDTH  monitored status bus.
REQ-008 SHALL have port: marker_list  input  NUM_MARK*WIDTH  expected markers; marker i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port: timeout_cycles  input  TO_W  per-marker wait limit; 0 disables the timeout.
REQ-010 SHALL have port: busy  output  1  high in RUN.
REQ-011 SHALL have port: pass  output  1  high in PASS.
REQ-012 SHALL have port: fail  output  1  high in FAIL.
REQ-013 SHALL have port: fail_code  output  2  0 none, 1 timeout, 2 order violation.
REQ-014 SHALL have port: match_idx  output  $clog2(NUM_MARK+1)  count of markers matched so far.
REQ-015 SHALL have port: change_pulse  output  1  one-cycle pulse when checkbits differs from the previous cycle's value while in RUN.
REQ-016 SHALL have port: change_cnt  output  16  saturating count of change_pulse events since the last arm.

Function
REQ-017 SHALL implement states IDLE, RUN, PASS and FAIL.
REQ-018 SHALL, on start in any state, enter RUN on the next edge with match_idx=0, timer=0, change_cnt=0 and fail_code=0.
REQ-019 SHALL, in RUN, advance match_idx by 1 and clear the timer in each cycle in which checkbits equals marker[match_idx].
REQ-020 SHALL evaluate at most one marker per cycle; identical consecutive markers with checkbits held therefore advance on consecutive cycles.
REQ-021 SHALL enter PASS on the edge where match_idx reaches NUM_MARK, with 1-cycle latency from the final match.
REQ-022 SHALL, when timeout_cycles != 0, increment the timer every RUN cycle without a match.
REQ-023 SHALL enter FAIL with fail_code=1 when the timer equals timeout_cycles-1 and no match occurs in that cycle.
REQ-024 SHALL give priority to a match over a timeout in the same cycle.
REQ-025 SHALL give priority to start over all other RUN events in the same cycle.
REQ-026 SHALL hold PASS and FAIL, together with all outputs, until start or reset is applied.
REQ-027 SHALL register the previous checkbits value every cycle regardless of state.
REQ-028 SHALL assert change_pulse only in RUN.
REQ-029 SHALL saturate change_cnt at 16'hFFFF.
REQ-030 SHALL sample timeout_cycles and marker_list combinationally each cycle; software holds them stable while busy.

Reset
REQ-031 SHALL, on reset, set state=IDLE, busy=0, pass=0, fail=0, fail_code=0, match_idx=0, change_pulse=0, change_cnt=0, timer=0 and previous value=0.
REQ-032 SHALL, when reset is asserted mid-RUN, abort to IDLE with no pass/fail indication.
REQ-033 SHALL give reset priority over start.

Configuration
REQ-034 SHALL, with CHECKBITS_MON_STRICT_ORDER_EN defined, enter FAIL with fail_code=2 when in RUN checkbits equals marker[j] for some j>match_idx and does not equal marker[match_idx].
REQ-035 SHALL, without CHECKBITS_MON_STRICT_ORDER_EN, ignore out-of-order values, never produce fail_code=2, and omit the comparison logic.

Verification
REQ-036 SHALL cover: WIDTH=16, NUM_MARK=2, markers {AB40,AB51}, timeout 1000; drive AB40, then 0x0028, then AB51 -> pass=1 one cycle after AB51; match_idx=2; change_cnt=3.
REQ-037 SHALL cover: same setup; drive AB40, then hold 0x0000 for 1000 cycles -> fail=1, fail_code=1 at the 1000th cycle after the AB40 match.
REQ-038 SHALL cover: timeout 5; AB51 presented on the cycle where timer=4 after AB40 -> pass, no fail.
REQ-039 SHALL cover: with CHECKBITS_MON_STRICT_ORDER_EN, drive AB51 before AB40 -> fail_code=2; without the macro, the same stimulus followed by AB40, AB51 -> pass.
REQ-040 SHALL cover: reset mid-RUN at match_idx=1 -> all outputs 0 next edge; start re-arms, then AB40, AB51 -> pass.
REQ-041 SHALL cover: markers {1234,1234}, checkbits held at 1234 -> match_idx 1 then 2 on consecutive cycles, then pass.
